// File: rtl/arbiter4_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter4_ctrl
//  Description : 4-requester arbiter with fixed or round-robin priority,
//                owner release via done/withdrawal and an optional hold limit.
//  Revision    : 1.0  initial release
// ============================================================================
module arbiter4_ctrl #(
    parameter int RR_EN    = 1,
    parameter int HOLD_MAX = 15,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_v,
    output logic       timeout
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    gnt_id_q, gnt_id_d;
    logic          gnt_v_q, gnt_v_d;
    logic          timeout_q, timeout_d;

    logic [1:0]    win;
    logic [1:0]    idx;
    logic          found;
    logic          rel_done, rel_wd, rel_to;

    // Winner search: round-robin scans upward from the pointer, fixed mode
    // lets the highest set index overwrite lower ones.
    always_comb begin
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        if (RR_EN != 0) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_q + 2'(k);
                if (!found && req[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (req[k]) begin
                    win = 2'(k);
                end
            end
        end
    end

    assign rel_done = done;
    assign rel_wd   = ~req[gnt_id_q];
    assign rel_to   = (HOLD_MAX != 0) && (hold_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_v_d   = gnt_v_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    state_d  = S_GRANT;
                    gnt_d    = 4'b0001 << win;
                    gnt_id_d = win;
                    gnt_v_d  = 1'b1;
                    hold_d   = CW'(1);
                    ptr_d    = win + 2'd1;
                end
            end
            S_GRANT: begin
                if (rel_done || rel_wd || rel_to) begin
                    state_d   = S_IDLE;
                    gnt_d     = 4'b0000;
                    gnt_id_d  = 2'd0;
                    gnt_v_d   = 1'b0;
                    timeout_d = rel_to && !rel_done && !rel_wd;
                end else if (hold_q != {CW{1'b1}}) begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            ptr_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            gnt_v_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_v_q   <= gnt_v_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_v   = gnt_v_q;
    assign timeout = timeout_q;

endmodule
`default_nettype wire
